// File: rtl/pll_reset_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_reset_seq_pkg;

    typedef enum logic [2:0] {
        PLLRST,
        WAITLOCK,
        FILTER,
        RELEASE,
        RUN
    } state_t;

    localparam int RELOCK_W = 8;

    // One shared counter covers every timed phase, so size it for the longest one.
    function automatic int ctr_width(input int rst_cycles, input int filter_cycles,
                                     input int gap_cycles, input int timeout_cycles);
        int m;
        m = rst_cycles;
        if (filter_cycles > m) m = filter_cycles;
        if (gap_cycles > m) m = gap_cycles;
        if (timeout_cycles > m) m = timeout_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level signals; resets to zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, debounces lock, then releases staged domain resets.
// Optional macro PLL_RESET_SEQ_SWRST_EN adds a synchronous software reset input sw_rst.
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 3,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_FILTER    = 1024,
    parameter int STAGE_GAP      = 256,
    parameter int RELOCK_TIMEOUT = 5000000
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  locked,
`ifdef PLL_RESET_SEQ_SWRST_EN
    input  logic                  sw_rst,
`endif
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [RELOCK_W-1:0]   relock_count
);

    localparam int CTR_W = ctr_width(PLL_RST_CYCLES, LOCK_FILTER, STAGE_GAP, RELOCK_TIMEOUT);
    localparam logic [CTR_W-1:0] PLLRST_LAST  = CTR_W'(PLL_RST_CYCLES - 1);
    // The WAITLOCK sample that enters FILTER is the first of the LOCK_FILTER high samples.
    localparam logic [CTR_W-1:0] FILTER_LAST  = CTR_W'((LOCK_FILTER >= 2) ? LOCK_FILTER - 2 : 0);
    localparam logic [CTR_W-1:0] GAP_LAST     = CTR_W'(STAGE_GAP - 1);
    localparam logic [CTR_W-1:0] TIMEOUT_LAST = CTR_W'(RELOCK_TIMEOUT - 1);
    localparam logic [NUM_STAGES-1:0] ALL_ONES = '1;

    logic locked_s;
    logic sw_req;

    state_t                state_reg, state_next;
    logic [CTR_W-1:0]      counter_reg, counter_next;
    logic [NUM_STAGES-1:0] rst_out_reg, rst_out_next;
    logic [NUM_STAGES-1:0] shifted;
    logic [RELOCK_W-1:0]   relock_reg, relock_next;
    logic                  pll_rst_reg;
    logic                  ready_reg;
    logic                  bump;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

`ifdef PLL_RESET_SEQ_SWRST_EN
    assign sw_req = sw_rst;
`else
    assign sw_req = 1'b0;
`endif

    // Releasing the next stage is a left shift: zeros enter from bit 0 upward.
    assign shifted = rst_out_reg << 1;

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg + CTR_W'(1);
        rst_out_next = rst_out_reg;
        relock_next  = relock_reg;
        bump         = 1'b0;

        case (state_reg)
            PLLRST: begin
                rst_out_next = ALL_ONES;
                if (counter_reg == PLLRST_LAST) state_next = WAITLOCK;
            end
            WAITLOCK: begin
                rst_out_next = ALL_ONES;
                if (locked_s) begin
                    if (LOCK_FILTER == 1) begin
                        rst_out_next = shifted;
                        state_next   = (shifted == '0) ? RUN : RELEASE;
                    end else begin
                        state_next = FILTER;
                    end
                end else if (counter_reg == TIMEOUT_LAST) begin
                    state_next = PLLRST;
                    bump       = 1'b1;
                end
            end
            FILTER: begin
                if (!locked_s) begin
                    state_next = WAITLOCK;
                end else if (counter_reg == FILTER_LAST) begin
                    rst_out_next = shifted;
                    state_next   = (shifted == '0) ? RUN : RELEASE;
                end
            end
            RELEASE, RUN: begin
                if (!locked_s) begin
                    state_next   = WAITLOCK;
                    rst_out_next = ALL_ONES;
                    bump         = 1'b1;
                end else if (state_reg == RELEASE && counter_reg == GAP_LAST) begin
                    rst_out_next = shifted;
                    counter_next = '0;
                    if (shifted == '0) state_next = RUN;
                end
            end
            default: begin
                state_next   = PLLRST;
                rst_out_next = ALL_ONES;
            end
        endcase

        // Software reset holds PLLRST with the pulse timer parked at zero.
        if (sw_req) begin
            state_next   = PLLRST;
            rst_out_next = ALL_ONES;
            bump         = 1'b0;
        end

        if (state_next != state_reg || sw_req || state_next == RUN) counter_next = '0;
        if (bump && relock_reg != '1) relock_next = relock_reg + RELOCK_W'(1);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_reg   <= PLLRST;
            counter_reg <= '0;
            rst_out_reg <= ALL_ONES;
            relock_reg  <= '0;
            pll_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            rst_out_reg <= rst_out_next;
            relock_reg  <= relock_next;
            pll_rst_reg <= (state_next == PLLRST);
            ready_reg   <= (state_next == RUN);
        end
    end

    assign pll_rst      = pll_rst_reg;
    assign rst_out      = rst_out_reg;
    assign ready        = ready_reg;
    assign relock_count = relock_reg;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq against a count-based behavioural model.
`timescale 1ns/1ps
module tb_pll_reset_seq;

    localparam int N   = 3;
    localparam int PRC = 4;
    localparam int LF  = 8;
    localparam int SG  = 4;
    localparam int RT  = 50;

    logic refclk = 1'b0;
    logic rst    = 1'b0;
    logic locked = 1'b0;
`ifdef PLL_RESET_SEQ_SWRST_EN
    logic sw_rst = 1'b0;
`endif
    logic         pll_rst;
    logic [N-1:0] rst_out;
    logic         ready;
    logic [7:0]   relock_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 refclk = ~refclk;

    pll_reset_seq #(
        .NUM_STAGES     (N),
        .PLL_RST_CYCLES (PRC),
        .LOCK_FILTER    (LF),
        .STAGE_GAP      (SG),
        .RELOCK_TIMEOUT (RT)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .locked       (locked),
`ifdef PLL_RESET_SEQ_SWRST_EN
        .sw_rst       (sw_rst),
`endif
        .pll_rst      (pll_rst),
        .rst_out      (rst_out),
        .ready        (ready),
        .relock_count (relock_count)
    );

    // Reference model: tracks pulse age, unlocked wait time, consecutive lock samples
    // and number of released stages rather than a state machine.
    logic       ls1 = 1'b0, ls2 = 1'b0;
    logic       m_pll = 1'b1;
    int         m_age = 0, m_wait = 0, m_good = 0, m_rel = 0, m_gap = 0;
    logic [7:0] m_relock = 8'd0;
    logic [N-1:0] m_rst_out;
    logic       m_ready;

    always @(posedge refclk or posedge rst) begin
        logic ls;
        logic sw;
        if (rst) begin
            ls1 = 1'b0; ls2 = 1'b0; m_pll = 1'b1;
            m_age = 0; m_wait = 0; m_good = 0; m_rel = 0; m_gap = 0; m_relock = 8'd0;
        end else begin
            ls = ls2; ls2 = ls1; ls1 = locked;
`ifdef PLL_RESET_SEQ_SWRST_EN
            sw = sw_rst;
`else
            sw = 1'b0;
`endif
            if (sw) begin
                m_pll = 1'b1; m_age = 0; m_rel = 0; m_gap = 0; m_good = 0; m_wait = 0;
            end else if (m_pll) begin
                m_age++;
                if (m_age == PRC) begin m_pll = 1'b0; m_wait = 0; m_good = 0; end
            end else if (m_rel > 0) begin
                if (!ls) begin
                    m_rel = 0; m_gap = 0; m_wait = 0; m_good = 0;
                    if (m_relock != 8'd255) m_relock++;
                end else if (m_rel < N) begin
                    m_gap++;
                    if (m_gap == SG) begin m_rel++; m_gap = 0; end
                end
            end else if (ls) begin
                m_good++;
                if (m_good == LF) begin m_rel = 1; m_gap = 0; m_good = 0; end
            end else if (m_good > 0) begin
                m_good = 0; m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == RT) begin
                    m_pll = 1'b1; m_age = 0;
                    if (m_relock != 8'd255) m_relock++;
                end
            end
        end
    end

    always_comb begin
        m_rst_out = ~((N'(1) << m_rel) - N'(1));
        m_ready   = (m_rel == N);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset;
        locked = 1'b0;
`ifdef PLL_RESET_SEQ_SWRST_EN
        sw_rst = 1'b0;
`endif
        @(negedge refclk);
        rst = 1'b1;
        @(negedge refclk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({pll_rst, rst_out, ready, relock_count} !== {1'b1, 3'b111, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_async got %b/%b/%b/%0d want 1/111/0/0", pll_rst, rst_out, ready, relock_count);
        end
        repeat (3) @(negedge refclk);
        n_cmp++;
        if ({pll_rst, rst_out, ready, relock_count} !== {1'b1, 3'b111, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_held got %b/%b/%b/%0d want 1/111/0/0", pll_rst, rst_out, ready, relock_count);
        end
        rst = 1'b0;
        $display("reset: outputs checked while rst held");
    endtask

    task automatic test_nominal(input int rise);
        int pfall, fall0, fall1, rdy;
        pfall = -1; fall0 = -1; fall1 = -1; rdy = -1;
        apply_reset();
        for (int c = 0; c <= rise + 30; c++) begin
            n_cmp++;
            if ({pll_rst, rst_out, ready, relock_count} !== {m_pll, m_rst_out, m_ready, m_relock}) begin
                n_bad++;
                $display("FAIL nominal c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         pll_rst, rst_out, ready, relock_count, m_pll, m_rst_out, m_ready, m_relock);
            end
            if (pfall < 0 && pll_rst === 1'b0) pfall = c;
            if (fall0 < 0 && rst_out[0] === 1'b0) fall0 = c;
            if (fall1 < 0 && rst_out[1] === 1'b0) fall1 = c;
            if (rdy < 0 && ready === 1'b1) rdy = c;
            locked = (c >= rise);
            @(negedge refclk);
        end
        n_cmp++;
        if (pfall != PRC) begin n_bad++; $display("FAIL nominal_pll_fall got %0d want %0d", pfall, PRC); end
        n_cmp++;
        if (fall0 != rise + LF + 2) begin n_bad++; $display("FAIL nominal_stage0 got %0d want %0d", fall0, rise + LF + 2); end
        n_cmp++;
        if (fall1 != fall0 + SG) begin n_bad++; $display("FAIL nominal_stage1 got %0d want %0d", fall1, fall0 + SG); end
        n_cmp++;
        if (rdy != fall0 + 2 * SG) begin n_bad++; $display("FAIL nominal_ready got %0d want %0d", rdy, fall0 + 2 * SG); end
        $display("nominal: locked rise at cycle %0d, stage0 released at %0d, ready at %0d", rise, fall0, rdy);
    endtask

    task automatic test_timeout;
        int k, rise_c;
        logic prev;
        k = 0; rise_c = 0; prev = 1'b1;
        apply_reset();
        for (int c = 0; c <= 3 * (PRC + RT) + 10; c++) begin
            n_cmp++;
            if ({pll_rst, rst_out, ready, relock_count} !== {m_pll, m_rst_out, m_ready, m_relock}) begin
                n_bad++;
                $display("FAIL timeout c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         pll_rst, rst_out, ready, relock_count, m_pll, m_rst_out, m_ready, m_relock);
            end
            if (pll_rst === 1'b1 && prev === 1'b0) begin
                k++; rise_c = c;
                n_cmp++;
                if (c != k * (PRC + RT) || relock_count !== 8'(k)) begin
                    n_bad++;
                    $display("FAIL timeout_pulse got cycle %0d count %0d want cycle %0d count %0d",
                             c, relock_count, k * (PRC + RT), k);
                end
            end
            if (pll_rst === 1'b0 && prev === 1'b1 && k > 0) begin
                n_cmp++;
                if (c - rise_c != PRC) begin n_bad++; $display("FAIL timeout_width got %0d want %0d", c - rise_c, PRC); end
            end
            prev = pll_rst;
            @(negedge refclk);
        end
        n_cmp++;
        if (k != 3 || relock_count !== 8'd3) begin
            n_bad++;
            $display("FAIL timeout_total got pulses=%0d count=%0d want 3/3", k, relock_count);
        end
        $display("timeout: %0d re-pulses, relock_count=%0d", k, relock_count);
    endtask

    task automatic test_glitch;
        int r, g, fall0;
        r = $urandom_range(3, 20);
        g = r + 3 + $urandom_range(0, 3);
        fall0 = -1;
        apply_reset();
        for (int c = 0; c <= g + 20; c++) begin
            n_cmp++;
            if ({pll_rst, rst_out, ready, relock_count} !== {m_pll, m_rst_out, m_ready, m_relock}) begin
                n_bad++;
                $display("FAIL glitch c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         pll_rst, rst_out, ready, relock_count, m_pll, m_rst_out, m_ready, m_relock);
            end
            if (fall0 < 0 && rst_out[0] === 1'b0) fall0 = c;
            locked = (c >= r) && (c != g);
            @(negedge refclk);
        end
        n_cmp++;
        if (fall0 != g + LF + 3) begin n_bad++; $display("FAIL glitch_stage0 got %0d want %0d", fall0, g + LF + 3); end
        n_cmp++;
        if (relock_count !== 8'd0) begin n_bad++; $display("FAIL glitch_relock got %0d want 0", relock_count); end
        $display("glitch: rise %0d, 1-cycle drop at %0d, stage0 released at %0d", r, g, fall0);
    endtask

    task automatic test_run_loss;
        int lc, d, rdy2;
        lc = 25; d = $urandom_range(1, 3); rdy2 = -1;
        apply_reset();
        for (int c = 0; c <= lc + d + 25; c++) begin
            n_cmp++;
            if ({pll_rst, rst_out, ready, relock_count} !== {m_pll, m_rst_out, m_ready, m_relock}) begin
                n_bad++;
                $display("FAIL run_loss c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         pll_rst, rst_out, ready, relock_count, m_pll, m_rst_out, m_ready, m_relock);
            end
            if (c == lc + 3) begin
                n_cmp++;
                if (rst_out !== 3'b111 || ready !== 1'b0 || relock_count !== 8'd1) begin
                    n_bad++;
                    $display("FAIL run_loss_force got %b/%b/%0d want 111/0/1", rst_out, ready, relock_count);
                end
            end
            if (rdy2 < 0 && c > lc + 3 && ready === 1'b1) rdy2 = c;
            locked = (c >= 3) && !(c >= lc && c < lc + d);
            @(negedge refclk);
        end
        n_cmp++;
        if (rdy2 != lc + d + LF + 2 + 2 * SG) begin
            n_bad++;
            $display("FAIL run_loss_relock got %0d want %0d", rdy2, lc + d + LF + 2 + 2 * SG);
        end
        $display("run_loss: %0d-cycle drop, ready again at cycle %0d", d, rdy2);
    endtask

    task automatic test_random;
        int hold;
        hold = 0;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            n_cmp++;
            if ({pll_rst, rst_out, ready, relock_count} !== {m_pll, m_rst_out, m_ready, m_relock}) begin
                n_bad++;
                $display("FAIL random c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         pll_rst, rst_out, ready, relock_count, m_pll, m_rst_out, m_ready, m_relock);
            end
            if (hold == 0) begin
                locked = ($urandom_range(0, 3) != 0);
                hold = $urandom_range(0, 1) ? $urandom_range(0, 2) : $urandom_range(1, 70);
            end else begin
                hold--;
            end
            @(negedge refclk);
        end
        $display("random: 3000 cycles, relock_count=%0d", relock_count);
    endtask

    task automatic test_saturation;
        apply_reset();
        for (int c = 0; c < 260 * (PRC + RT) + 20; c++) begin
            n_cmp++;
            if ({pll_rst, rst_out, ready, relock_count} !== {m_pll, m_rst_out, m_ready, m_relock}) begin
                n_bad++;
                $display("FAIL saturation c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         pll_rst, rst_out, ready, relock_count, m_pll, m_rst_out, m_ready, m_relock);
            end
            @(negedge refclk);
        end
        n_cmp++;
        if (relock_count !== 8'd255) begin n_bad++; $display("FAIL saturation_count got %0d want 255", relock_count); end
        for (int i = 0; i < 10 && m_pll; i++) @(negedge refclk);
        locked = 1'b1;
        repeat (LF + 4) @(negedge refclk);
        n_cmp++;
        if (rst_out !== 3'b110 || ready !== 1'b0) begin
            n_bad++;
            $display("FAIL saturation_in_release got %b/%b want 110/0", rst_out, ready);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({pll_rst, rst_out, ready, relock_count} !== {1'b1, 3'b111, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL saturation_async_rst got %b/%b/%b/%0d want 1/111/0/0", pll_rst, rst_out, ready, relock_count);
        end
        @(negedge refclk);
        rst = 1'b0;
        locked = 1'b0;
        $display("saturation: relock_count held at 255, async reset mid-release checked");
    endtask

`ifdef PLL_RESET_SEQ_SWRST_EN
    task automatic test_sw_rst;
        int fall_c;
        fall_c = -1;
        apply_reset();
        for (int c = 0; c <= 40; c++) begin
            n_cmp++;
            if ({pll_rst, rst_out, ready, relock_count} !== {m_pll, m_rst_out, m_ready, m_relock}) begin
                n_bad++;
                $display("FAIL sw_rst c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         pll_rst, rst_out, ready, relock_count, m_pll, m_rst_out, m_ready, m_relock);
            end
            if (c == 26) begin
                n_cmp++;
                if ({pll_rst, rst_out, ready, relock_count} !== {1'b1, 3'b111, 1'b0, 8'd0}) begin
                    n_bad++;
                    $display("FAIL sw_rst_force got %b/%b/%b/%0d want 1/111/0/0", pll_rst, rst_out, ready, relock_count);
                end
            end
            if (fall_c < 0 && c > 26 && pll_rst === 1'b0) fall_c = c;
            locked = (c >= 3);
            sw_rst = (c == 25);
            @(negedge refclk);
        end
        n_cmp++;
        if (fall_c != 26 + PRC) begin n_bad++; $display("FAIL sw_rst_width got %0d want %0d", fall_c, 26 + PRC); end
        $display("sw_rst: pulse in RUN, pll_rst released at cycle %0d", fall_c);
    endtask
`endif

    initial begin
        test_reset();
        test_nominal(20);
        test_nominal($urandom_range(3, 40));
        test_timeout();
        test_glitch();
        test_glitch();
        test_run_loss();
        test_random();
        test_saturation();
`ifdef PLL_RESET_SEQ_SWRST_EN
        test_sw_rst();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
Reset sequencer directly downstream of the system PLL wrapper, running on the stable board reference clock.
- Drives the PLL's reset pin and consumes its asynchronous locked output.
- After a debounced lock, releases a staged set of active-high resets for the derived clock domains.
- Re-pulses the PLL reset on lock timeout and forces all resets on loss of lock.

Parameters:
NUM_STAGES, 3, number of staged reset outputs, one per PLL output clock domain
PLL_RST_CYCLES, 16, width in refclk cycles of each pll_rst pulse (min 1)
LOCK_FILTER, 1024, consecutive cycles locked_s must stay high before release (min 1)
STAGE_GAP, 256, cycles between successive stage releases (min 1)
RELOCK_TIMEOUT, 5000000, cycles to wait in WAITLOCK before re-pulsing pll_rst (100 ms at 50 MHz)

Ports:
refclk  input  1  reference clock (50 MHz board clock, not a PLL output)
rst  input  1  asynchronous active-high reset
locked  input  1  PLL lock indicator, asynchronous to refclk
pll_rst  output  1  reset to the PLL, active-high
rst_out  output  NUM_STAGES  active-high stage resets; bit 0 released first
ready  output  1  high when all stages are released and lock is held
relock_count  output  8  saturating count of relock events

Behaviour:
- Interface: one clock, refclk; reset is asynchronous and active-high, named rst.
- Reset values (while rst=1): pll_rst=1, rst_out=all ones, ready=0, relock_count=0, state=PLLRST, counter=0, sync flops=0.
- Synchronisation: locked passes through a 2-flop synchroniser to produce locked_s. Only locked_s is used.
- Counter: a single shared counter, width clog2(max of all cycle parameters)+1. It is cleared on every state change.
- PLLRST:
  - pll_rst=1.
  - After PLL_RST_CYCLES cycles, go to WAITLOCK; pll_rst falls on that edge.
- WAITLOCK:
  - pll_rst=0.
  - If locked_s=1, go to FILTER.
  - Otherwise, when the counter reaches RELOCK_TIMEOUT-1, go to PLLRST and increment relock_count.
- FILTER:
  - If locked_s=0, return to WAITLOCK; the timeout restarts from 0.
  - When locked_s has been sampled high for LOCK_FILTER consecutive cycles, go to RELEASE; rst_out[0] falls on the same edge.
- RELEASE:
  - rst_out[k] falls k*STAGE_GAP cycles after rst_out[0].
  - Released bits stay low; no bit is ever released before a lower-index bit.
  - On the edge that releases bit NUM_STAGES-1, ready rises and state goes to RUN.
- RUN: ready=1, rst_out=0, pll_rst=0.
- Lock loss: locked_s=0 while in RELEASE or RUN causes all of the following on the next edge:
  - rst_out=all ones, ready=0;
  - relock_count increments;
  - state goes to WAITLOCK. The PLL is not reset; the timeout governs any re-pulse.
- relock_count saturates at 255 and never wraps. It is cleared only by rst.
- Glitch rule: a locked_s low pulse of 1 cycle in FILTER restarts the filter. The same pulse in RUN still forces a full reset.
- NUM_STAGES=1: rst_out[0] and ready change on the same edge.
- rst asserted mid-sequence: all outputs return to reset values asynchronously; the sequence restarts from PLLRST after deassertion.

Optional Feature:
PLL_RESET_SEQ_SWRST_EN
- Defined: adds input sw_rst (1 bit, synchronous to refclk, active-high). sw_rst=1 in any state forces PLLRST on the next edge with rst_out=all ones and ready=0. relock_count is not incremented. PLLRST holds while sw_rst remains high, and PLL_RST_CYCLES counts from sw_rst deassertion.
- Undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package pll_reset_seq_pkg contains:
  - state enum: PLLRST, WAITLOCK, FILTER, RELEASE, RUN;
  - relock_count width constant (8);
  - function computing the counter width from the parameters.
- Sub-module sync_2ff: parameterised-width 2-flop synchroniser with async active-high reset to 0. It is reused for locked and for future cross-domain flags.

Test Plan:
All scenarios use NUM_STAGES=3, PLL_RST_CYCLES=4, LOCK_FILTER=8, STAGE_GAP=4, RELOCK_TIMEOUT=50.
- Nominal bring-up: rst released, locked rises at cycle 20 -> pll_rst high for cycles 0-3. rst_out[0] falls 10 cycles after locked rise (±1). rst_out[1] falls 4 cycles later. rst_out[2] and ready fall/rise 8 cycles after rst_out[0].
- Lock timeout: locked held 0 -> pll_rst re-pulses for 4 cycles every 54 cycles. relock_count goes 1, 2, 3.
- Filter glitch: locked low for 1 cycle, 5 cycles into FILTER -> filter restarts. rst_out[0] falls 8 cycles after locked_s re-rises. relock_count unchanged.
- Lock loss in RUN: drop locked -> within 3 edges rst_out=3'b111, ready=0, relock_count+1. Relock -> full staged release repeats.
- Saturation and reset: force 260 timeouts -> relock_count=255. Assert rst mid-RELEASE -> all outputs immediately return to reset values, with no refclk edge required.
- With PLL_RESET_SEQ_SWRST_EN: sw_rst pulsed 1 cycle in RUN -> next edge pll_rst=1, rst_out=all ones, ready=0. pll_rst stays high for 4 cycles. relock_count unchanged.
